// File: rtl/impact_sram_sequencer.sv
// rtl/impact_sram_sequencer.sv - single-word access sequencer for the 32x32 IMPACT SRAM bank
//
// Runs each accepted request through PRECH -> ACCESS -> RECOV -> IDLE.
// Array drive outputs are decoded from the state, so break-before-make
// follows from the state order. Read data and sense error are registered
// at the last ACCESS edge.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   ctl_en                   enable; gates req_ready
//   cfg_tpre, cfg_twl        phase lengths in cycles (0 acts as 1), sampled at accept
//   req_*                    valid/ready request channel (we, addr, wdata)
//   rsp_valid/rdata/err      completion pulse, held read data, sense error
//   busy                     high in any non-IDLE state
//   wl, bl_out, blb_out, bl_oe   array pad drive
//   bl_in, blb_in            sensed bitline pairs
module impact_sram_sequencer #(
  parameter int NWL   = 32,
  parameter int NBL   = 32,
  parameter int CNT_W = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ctl_en,
  input  logic [CNT_W-1:0] cfg_tpre,
  input  logic [CNT_W-1:0] cfg_twl,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [4:0]       req_addr,
  input  logic [NBL-1:0]   req_wdata,
  output logic             rsp_valid,
  output logic [NBL-1:0]   rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic [NWL-1:0]   wl,
  output logic [NBL-1:0]   bl_out,
  output logic [NBL-1:0]   blb_out,
  output logic             bl_oe,
  input  logic [NBL-1:0]   bl_in,
  input  logic [NBL-1:0]   blb_in
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRECH  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RECOV  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tw_q;
  logic             we_q;
  logic [4:0]       addr_q;
  logic [NBL-1:0]   wdata_q;

  logic             accept;
  logic [CNT_W-1:0] tp_eff;
  logic [CNT_W-1:0] tw_eff;

  assign req_ready = (state == S_IDLE) & ctl_en;
  assign accept    = req_valid & req_ready;
  assign tp_eff    = (cfg_tpre == CNT_ZERO) ? CNT_ONE : cfg_tpre;
  assign tw_eff    = (cfg_twl  == CNT_ZERO) ? CNT_ONE : cfg_twl;

  // cnt holds the cycles remaining in the current phase minus one, so the
  // phase ends on the cycle where it reads zero.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= CNT_ZERO;
      tw_q      <= CNT_ZERO;
      we_q      <= 1'b0;
      addr_q    <= 5'd0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            tw_q    <= tw_eff;
            cnt     <= tp_eff - CNT_ONE;
            state   <= S_PRECH;
          end
        end
        S_PRECH: begin
          if (cnt == CNT_ZERO) begin
            cnt   <= tw_q - CNT_ONE;
            state <= S_ACCESS;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_ACCESS: begin
          if (cnt == CNT_ZERO) begin
            state <= S_RECOV;
            if (we_q) begin
              rsp_err <= 1'b0;
            end else begin
              rsp_rdata <= bl_in & ~blb_in;
              // a healthy pair is always differential; equal levels mean a failed sense
              rsp_err   <= |(~(bl_in ^ blb_in));
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_RECOV: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wl        = '0;
    bl_out    = '0;
    blb_out   = '0;
    bl_oe     = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_PRECH: begin
        busy    = 1'b1;
        bl_oe   = 1'b1;
        bl_out  = '1;
        blb_out = '1;
      end
      S_ACCESS: begin
        busy = 1'b1;
        wl   = {{(NWL-1){1'b0}}, 1'b1} << addr_q;
        if (we_q) begin
          bl_oe   = 1'b1;
          bl_out  = wdata_q;
          blb_out = ~wdata_q;
        end
      end
      S_RECOV: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_impact_sram_sequencer.sv
// tb/tb_impact_sram_sequencer.sv - self-checking bench for impact_sram_sequencer
module tb_impact_sram_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctl_en = 1'b1;
  logic [3:0]  cfg_tpre = 4'd2;
  logic [3:0]  cfg_twl = 4'd3;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] wl;
  logic [31:0] bl_out;
  logic [31:0] blb_out;
  logic        bl_oe;
  logic [31:0] bl_in = 32'd0;
  logic [31:0] blb_in = 32'd0;

  impact_sram_sequencer #(.NWL(32), .NBL(32), .CNT_W(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .ctl_en   (ctl_en),
    .cfg_tpre (cfg_tpre),
    .cfg_twl  (cfg_twl),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .wl       (wl),
    .bl_out   (bl_out),
    .blb_out  (blb_out),
    .bl_oe    (bl_oe),
    .bl_in    (bl_in),
    .blb_in   (blb_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Reference model: one in-flight access described by its accept cycle
  // and phase lengths; outputs follow from the cycle offset.
  bit          mdl_on = 1'b0;
  bit          m_act = 1'b0;
  bit          m_we = 1'b0;
  int          m_n = 0, m_tp = 0, m_tw = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_wd = 32'd0, m_rd = 32'd0;
  bit          m_err = 1'b0;

  always @(negedge clk) begin
    if (mdl_on) begin
      int d;
      logic [31:0] e_wl, e_bo, e_bbo;
      logic e_oe, e_rv, e_busy, e_rdy;
      d = cyc - m_n;
      e_wl = 0; e_bo = 0; e_bbo = 0; e_oe = 0; e_rv = 0; e_busy = 0;
      e_rdy = ctl_en;
      if (m_act) begin
        e_rdy = 0;
        e_busy = 1;
        if (d <= m_tp) begin
          e_oe = 1; e_bo = 32'hFFFF_FFFF; e_bbo = 32'hFFFF_FFFF;
        end else if (d <= m_tp + m_tw) begin
          e_wl = 32'd1 << m_addr;
          if (m_we) begin
            e_oe = 1; e_bo = m_wd; e_bbo = ~m_wd;
          end
        end else begin
          e_rv = 1;
        end
      end
      chk("m_req_ready", {31'd0, req_ready}, {31'd0, e_rdy});
      chk("m_busy", {31'd0, busy}, {31'd0, e_busy});
      chk("m_wl", wl, e_wl);
      chk("m_wl_onehot0", {31'd0, $onehot0(wl)}, 32'd1);
      chk("m_bl_oe", {31'd0, bl_oe}, {31'd0, e_oe});
      chk("m_bl_out", bl_out, e_bo);
      chk("m_blb_out", blb_out, e_bbo);
      chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rv});
      chk("m_rsp_rdata", rsp_rdata, m_rd);
      if (e_rv) chk("m_rsp_err", {31'd0, rsp_err}, {31'd0, m_err});

      if (rst) begin
        m_act = 0; m_rd = 0; m_err = 0;
      end else begin
        if (m_act && d == m_tp + m_tw) begin
          if (m_we) m_err = 0;
          else begin
            m_rd = bl_in & ~blb_in;
            m_err = |(~(bl_in ^ blb_in));
          end
        end
        if (m_act && d == m_tp + m_tw + 1) m_act = 0;
        else if (!m_act && ctl_en && req_valid) begin
          m_act = 1; m_n = cyc; m_we = req_we; m_addr = req_addr; m_wd = req_wdata;
          m_tp = (cfg_tpre == 0) ? 1 : int'(cfg_tpre);
          m_tw = (cfg_twl == 0) ? 1 : int'(cfg_twl);
        end
      end
    end
  end

  // Called at posedge+1; returns the accept cycle, or -1 on timeout.
  task automatic send(input logic we, input logic [4:0] a, input logic [31:0] dat,
                      input logic [3:0] tp, input logic [3:0] tw, input bit hold,
                      output int n);
    req_we = we; req_addr = a; req_wdata = dat;
    cfg_tpre = tp; cfg_twl = tw; req_valid = 1'b1;
    n = -1;
    for (int i = 0; i < 60 && n < 0; i++) begin
      @(negedge clk);
      if (req_ready) n = cyc;
      @(posedge clk) #1;
    end
    if (n < 0) chk("accept_timeout", 32'd0, 32'd1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int n, n2, t0;
    @(posedge clk) #1;
    mdl_on = 1'b1;
    @(posedge clk) #1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wl", wl, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;

    // write addr 5, Tp=2 Tw=3
    t0 = cyc;
    send(1'b1, 5'd5, 32'hA5A5_0F0F, 4'd2, 4'd3, 1'b0, n);
    chk("wr_accept_cycle", n, t0);
    req_wdata = 32'hDEAD_BEEF; req_addr = 5'd9;
    go_to(n + 1);
    chk("wr_prech_wl", wl, 32'd0);
    chk("wr_prech_bl", bl_out, 32'hFFFF_FFFF);
    chk("wr_prech_blb", blb_out, 32'hFFFF_FFFF);
    go_to(n + 3);
    chk("wr_acc_wl", wl, 32'h0000_0020);
    chk("wr_acc_bl", bl_out, 32'hA5A5_0F0F);
    chk("wr_acc_blb", blb_out, 32'h5A5A_F0F0);
    chk("wr_acc_oe", {31'd0, bl_oe}, 32'd1);
    go_to(n + 5);
    chk("wr_acc_last_wl", wl, 32'h0000_0020);
    go_to(n + 6);
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_recov_wl", wl, 32'd0);
    go_to(n + 7);
    chk("wr_ready_again", {31'd0, req_ready}, 32'd1);
    @(posedge clk) #1;

    // read addr 31, clean differential
    bl_in = 32'h1234_5678; blb_in = 32'hEDCB_A987;
    send(1'b0, 5'd31, 32'h0, 4'd2, 4'd3, 1'b0, n);
    go_to(n + 4);
    chk("rd_acc_wl", wl, 32'h8000_0000);
    chk("rd_acc_oe", {31'd0, bl_oe}, 32'd0);
    go_to(n + 6);
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk) #1;

    // sense error on bit 0
    blb_in = 32'hEDCB_A986;
    send(1'b0, 5'd31, 32'h0, 4'd2, 4'd3, 1'b0, n);
    go_to(n + 6);
    chk("se_rdata", rsp_rdata, 32'h1234_5678);
    chk("se_err", {31'd0, rsp_err}, 32'd1);
    @(posedge clk) #1;

    // zero timing, cfg changed mid-access
    blb_in = 32'hEDCB_A987;
    send(1'b0, 5'd2, 32'h0, 4'd0, 4'd0, 1'b0, n);
    cfg_tpre = 4'd15; cfg_twl = 4'd15; req_addr = 5'd7;
    go_to(n + 2);
    chk("zt_acc_wl", wl, 32'h0000_0004);
    chk("zt_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
    go_to(n + 3);
    chk("zt_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk) #1;

    // reset during ACCESS of a write
    send(1'b1, 5'd3, 32'h0F0F_1234, 4'd2, 4'd3, 1'b0, n);
    go_to(n + 3);
    @(posedge clk) #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_wl", wl, 32'd0);
    chk("mr_oe", {31'd0, bl_oe}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_rdata", rsp_rdata, 32'd0);
    begin
      bit saw = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (rsp_valid) saw = 1;
      end
      chk("mr_no_rsp", {31'd0, saw}, 32'd0);
    end
    @(posedge clk) #1;

    // ctl_en gating, then back-to-back held request
    ctl_en = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd1;
    begin
      bit acc = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (req_ready) acc = 1;
        @(posedge clk) #1;
      end
      chk("en_no_accept", {31'd0, acc}, 32'd0);
    end
    ctl_en = 1'b1;
    t0 = cyc;
    send(1'b1, 5'd1, 32'h1111_2222, 4'd2, 4'd3, 1'b1, n);
    chk("en_accept_cycle", n, t0);
    send(1'b1, 5'd9, 32'h3333_4444, 4'd2, 4'd3, 1'b0, n2);
    chk("b2b_accept_cycle", n2, n + 7);
    go_to(n2 + 1);
    chk("b2b_gap_wl", wl, 32'd0);
    go_to(n2 + 3);
    chk("b2b_wl", wl, 32'h0000_0200);
    go_to(n2 + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
